// File: rtl/craps_round_ctrl.sv
// Craps round controller: registers the dice sum and runs the come-out/point FSM with point, roll count and win/loss tallies.
// Outputs update one cycle after the roll_valid/new_game cycle; no backpressure (every strobe is consumed or rejected immediately).
module craps_round_ctrl #(
    parameter int FACES = 6,
    parameter int CW    = 8,
    parameter int DW    = $clog2(FACES + 1),
    parameter int SW    = $clog2(2 * FACES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          roll_valid,
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] x1,
    input  logic          new_game,
    output logic [SW-1:0] sum,
    output logic [1:0]    result,
    output logic [SW-1:0] point,
    output logic [CW-1:0] roll_cnt,
    output logic [CW-1:0] wins,
    output logic [CW-1:0] losses,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_COME_OUT,
        ST_POINT,
        ST_WON,
        ST_LOST
    } state_t;

    localparam logic [1:0] RES_WIN   = 2'b00;
    localparam logic [1:0] RES_LOSE  = 2'b01;
    localparam logic [1:0] RES_AGAIN = 2'b10;
    localparam logic [1:0] RES_IDLE  = 2'b11;

    localparam logic [SW-1:0] SUM_SEVEN = SW'(FACES + 1);
    localparam logic [SW-1:0] SUM_NAT2  = SW'(2 * FACES - 1);
    localparam logic [SW-1:0] SUM_TWO   = SW'(2);
    localparam logic [SW-1:0] SUM_THREE = SW'(3);
    localparam logic [SW-1:0] SUM_MAX   = SW'(2 * FACES);
    localparam logic [DW-1:0] DIE_MAX   = DW'(FACES);

    state_t        state, state_nx;
    logic [SW-1:0] sum_nx, point_nx;
    logic [1:0]    result_nx;
    logic [CW-1:0] roll_cnt_nx, wins_nx, losses_nx;
    logic          err_nx;

    logic          legal;
    logic          in_round;
    logic [SW-1:0] roll_sum;
    logic          is_nat;
    logic          is_craps;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign legal    = (x0 != '0) && (x0 <= DIE_MAX) && (x1 != '0) && (x1 <= DIE_MAX);
    assign in_round = (state == ST_COME_OUT) || (state == ST_POINT);
    assign roll_sum = SW'(x0) + SW'(x1);
    assign is_nat   = (roll_sum == SUM_SEVEN) || (roll_sum == SUM_NAT2);
    assign is_craps = (roll_sum == SUM_TWO) || (roll_sum == SUM_THREE) || (roll_sum == SUM_MAX);

    always_comb begin
        state_nx    = state;
        sum_nx      = sum;
        result_nx   = result;
        point_nx    = point;
        roll_cnt_nx = roll_cnt;
        wins_nx     = wins;
        losses_nx   = losses;
        err_nx      = 1'b0;

        // new_game takes priority and silently discards a coincident roll
        if (new_game) begin
            state_nx    = ST_COME_OUT;
            result_nx   = RES_IDLE;
            point_nx    = '0;
            roll_cnt_nx = '0;
        end else if (in_round && roll_valid) begin
            if (!legal) begin
                err_nx = 1'b1;
            end else begin
                sum_nx      = roll_sum;
                roll_cnt_nx = sat_inc(roll_cnt);
                if (state == ST_COME_OUT) begin
                    if (is_nat) begin
                        state_nx  = ST_WON;
                        result_nx = RES_WIN;
                        wins_nx   = sat_inc(wins);
                    end else if (is_craps) begin
                        state_nx  = ST_LOST;
                        result_nx = RES_LOSE;
                        losses_nx = sat_inc(losses);
                    end else begin
                        state_nx  = ST_POINT;
                        point_nx  = roll_sum;
                        result_nx = RES_AGAIN;
                    end
                end else begin
                    if (roll_sum == point) begin
                        state_nx  = ST_WON;
                        result_nx = RES_WIN;
                        wins_nx   = sat_inc(wins);
                    end else if (roll_sum == SUM_SEVEN) begin
                        state_nx  = ST_LOST;
                        result_nx = RES_LOSE;
                        losses_nx = sat_inc(losses);
                    end else begin
                        result_nx = RES_AGAIN;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_COME_OUT;
            sum      <= '0;
            result   <= RES_IDLE;
            point    <= '0;
            roll_cnt <= '0;
            wins     <= '0;
            losses   <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            sum      <= sum_nx;
            result   <= result_nx;
            point    <= point_nx;
            roll_cnt <= roll_cnt_nx;
            wins     <= wins_nx;
            losses   <= losses_nx;
            err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_craps_round_ctrl.sv
// Bench for craps_round_ctrl (FACES=6, CW=2): directed rounds plus random traffic against a scoreboard.
module tb_craps_round_ctrl;

    localparam int FACES = 6;
    localparam int CW    = 2;
    localparam int DW    = 3;
    localparam int SW    = 4;
    localparam int CMAX  = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          roll_valid = 1'b0;
    logic [DW-1:0] x0 = '0;
    logic [DW-1:0] x1 = '0;
    logic          new_game = 1'b0;
    logic [SW-1:0] sum;
    logic [1:0]    result;
    logic [SW-1:0] point;
    logic [CW-1:0] roll_cnt;
    logic [CW-1:0] wins;
    logic [CW-1:0] losses;
    logic          err;

    craps_round_ctrl #(.FACES(FACES), .CW(CW)) dut (
        .clock(clock), .reset(reset), .roll_valid(roll_valid), .x0(x0), .x1(x1),
        .new_game(new_game), .sum(sum), .result(result), .point(point),
        .roll_cnt(roll_cnt), .wins(wins), .losses(losses), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int sum; int result; int point; int rc; int wins; int losses; int err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference model: 0 come-out, 1 point, 2 won, 3 lost
    int m_st = 0, m_sum = 0, m_res = 3, m_pt = 0, m_rc = 0, m_w = 0, m_l = 0, m_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model(input int rv, input int a, input int b, input int ng, input int rst);
        int s;
        m_err = 0;
        if (rst != 0) begin
            m_st = 0; m_sum = 0; m_res = 3; m_pt = 0; m_rc = 0; m_w = 0; m_l = 0;
        end else if (ng != 0) begin
            m_st = 0; m_res = 3; m_pt = 0; m_rc = 0;
        end else if (rv != 0 && m_st < 2) begin
            if (a < 1 || a > FACES || b < 1 || b > FACES) begin
                m_err = 1;
            end else begin
                s = a + b;
                m_sum = s;
                m_rc = sat(m_rc);
                if ((m_st == 0 && (s == 7 || s == 11)) || (m_st == 1 && s == m_pt)) begin
                    m_st = 2; m_res = 0; m_w = sat(m_w);
                end else if ((m_st == 0 && (s == 2 || s == 3 || s == 12)) || (m_st == 1 && s == 7)) begin
                    m_st = 3; m_res = 1; m_l = sat(m_l);
                end else begin
                    if (m_st == 0) m_pt = s;
                    m_st = 1; m_res = 2;
                end
            end
        end
    endtask

    task automatic cyc(input int rv, input int a, input int b, input int ng, input int rst);
        exp_t e;
        roll_valid = rv[0]; x0 = DW'(a); x1 = DW'(b); new_game = ng[0]; reset = rst[0];
        model(rv, a, b, ng, rst);
        e = '{m_sum, m_res, m_pt, m_rc, m_w, m_l, m_err};
        q.push_back(e);
        @(posedge clock);
        #1;
        roll_valid = 1'b0; new_game = 1'b0; reset = 1'b0;
        if (q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("sum", int'(sum), e.sum);
            chk("result", int'(result), e.result);
            chk("point", int'(point), e.point);
            chk("roll_cnt", int'(roll_cnt), e.rc);
            chk("wins", int'(wins), e.wins);
            chk("losses", int'(losses), e.losses);
            chk("err", int'(err), e.err);
        end
    endtask

    task automatic roll(input int a, input int b);
        cyc(1, a, b, 0, 0);
    endtask

    task automatic ng();
        cyc(0, 0, 0, 1, 0);
    endtask

    initial begin
        @(negedge clock);
        cyc(0, 0, 0, 0, 1);
        chk("rst_result", int'(result), 3);
        chk("rst_wins", int'(wins), 0);

        roll(3, 4);
        chk("nat_sum", int'(sum), 7);
        chk("nat_result", int'(result), 0);
        chk("nat_wins", int'(wins), 1);
        chk("nat_rc", int'(roll_cnt), 1);
        roll(2, 2);
        chk("won_hold_sum", int'(sum), 7);

        ng();
        roll(1, 1);
        chk("craps_result", int'(result), 1);
        chk("craps_losses", int'(losses), 1);
        chk("craps_sum", int'(sum), 2);
        ng();
        chk("ng_result", int'(result), 3);
        chk("ng_rc", int'(roll_cnt), 0);
        chk("ng_losses", int'(losses), 1);

        ng();
        roll(2, 2);
        chk("pt_result", int'(result), 2);
        chk("pt_point", int'(point), 4);
        roll(5, 1);
        chk("pt2_result", int'(result), 2);
        roll(3, 1);
        chk("made_result", int'(result), 0);
        chk("made_point", int'(point), 4);
        chk("made_rc", int'(roll_cnt), 3);

        ng();
        roll(5, 5);
        chk("p10_point", int'(point), 10);
        roll(6, 1);
        chk("sevenout_result", int'(result), 1);
        chk("sevenout_losses", int'(losses), 2);

        ng();
        roll(0, 3);
        chk("err0", int'(err), 1);
        chk("err0_sum", int'(sum), 7);
        cyc(0, 0, 0, 0, 0);
        chk("err_pulse", int'(err), 0);
        roll(7, 2);
        chk("err7", int'(err), 1);
        chk("err7_result", int'(result), 3);

        for (int g = 0; g < 5; g++) begin
            ng();
            roll(5, 6);
        end
        chk("wins_sat", int'(wins), 3);

        ng();
        roll(2, 2);
        for (int i = 0; i < 4; i++) roll(1, 2);
        chk("rc_sat", int'(roll_cnt), 3);

        cyc(1, 3, 4, 1, 0);
        chk("ng_roll_result", int'(result), 3);
        chk("ng_roll_rc", int'(roll_cnt), 0);

        roll(4, 4);
        chk("mid_point", int'(point), 8);
        cyc(1, 1, 1, 0, 1);
        chk("midrst_point", int'(point), 0);
        chk("midrst_sum", int'(sum), 0);
        chk("midrst_losses", int'(losses), 0);

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7),
                ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 99) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
